// File: rtl/delay_line.sv
`default_nettype none
// ============================================================================
// Module      : delay_line
// Description : Fixed-latency register chain for an arbitrary-width bus.
//               Used to align sideband signals (sync, data-valid, channel
//               index, ...) with datapath blocks of known latency. No
//               handshake and no backpressure: one word enters and one word
//               leaves on every enabled clock edge.
//
// Parameters  : WIDTH  bus width in bits (>= 1)
//               DELAY  latency in enabled clk cycles (>= 0);
//                      DELAY = 0 is a plain combinational pass-through
//
// Ports       : clk   in   1      clock, rising edge
//               rst   in   1      asynchronous, active-high reset
//               ce    in   1      clock enable (only with DELAY_LINE_CE_EN)
//               din   in   WIDTH  data in
//               dout  out  WIDTH  din delayed by DELAY enabled cycles
//
// Config      : DELAY_LINE_CE_EN  when defined, adds the ce port. When
//               undefined the chain shifts on every clk edge, exactly as if
//               ce were tied high.
//
// Revision    : 1.0  initial release
// ============================================================================
module delay_line #(
    parameter int WIDTH = 8,
    parameter int DELAY = 1
) (
    input  logic             clk,
    input  logic             rst,
`ifdef DELAY_LINE_CE_EN
    input  logic             ce,
`endif
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // Internal enable: the real port when the feature is built in,
    // otherwise a constant so the chain shifts every edge.
    logic w_ce;

`ifdef DELAY_LINE_CE_EN
    assign w_ce = ce;
`else
    assign w_ce = 1'b1;
`endif

    generate
        // Illegal configurations stop elaboration.
        if (WIDTH < 1) begin : g_bad_width
            $error("delay_line: WIDTH must be >= 1");
        end
        if (DELAY < 0) begin : g_bad_delay
            $error("delay_line: DELAY must be >= 0");
        end

        if (DELAY <= 0) begin : g_passthru
            // No storage at all: clk, rst and ce are intentionally ignored.
            logic w_unused;
            assign w_unused = ^{clk, rst, w_ce};
            assign dout     = din;
        end else begin : g_chain
            // r_stage[0] is nearest the input; dout taps the last stage, so
            // there is never a combinational path from din to dout.
            logic [WIDTH-1:0] r_stage [0:DELAY-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    // Reset discards every in-flight word and wins over ce.
                    for (int k = 0; k < DELAY; k++) begin
                        r_stage[k] <= '0;
                    end
                end else if (w_ce) begin
                    r_stage[0] <= din;
                    for (int k = 1; k < DELAY; k++) begin
                        r_stage[k] <= r_stage[k-1];
                    end
                end
            end

            assign dout = r_stage[DELAY-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : tb_delay_line
// Description : Directed self-checking bench for delay_line. Instantiates
//               WIDTH=10/DELAY=4, WIDTH=8/DELAY=0, WIDTH=8/DELAY=1 and, when
//               DELAY_LINE_CE_EN is defined, WIDTH=8/DELAY=3 with ce driven.
// Revision    : 1.0  initial release
// ============================================================================
module tb_delay_line;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic [9:0] din4, dout4;
    logic [7:0] din0, dout0;
    logic [7:0] din1, dout1;
    logic [7:0] din3, dout3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    delay_line #(.WIDTH(10), .DELAY(4)) u_dut4 (
        .clk  (clk),
        .rst  (rst),
`ifdef DELAY_LINE_CE_EN
        .ce   (1'b1),
`endif
        .din  (din4),
        .dout (dout4)
    );

    delay_line #(.WIDTH(8), .DELAY(0)) u_dut0 (
        .clk  (clk),
        .rst  (rst),
`ifdef DELAY_LINE_CE_EN
        .ce   (1'b1),
`endif
        .din  (din0),
        .dout (dout0)
    );

    delay_line #(.WIDTH(8), .DELAY(1)) u_dut1 (
        .clk  (clk),
        .rst  (rst),
`ifdef DELAY_LINE_CE_EN
        .ce   (1'b1),
`endif
        .din  (din1),
        .dout (dout1)
    );

`ifdef DELAY_LINE_CE_EN
    delay_line #(.WIDTH(8), .DELAY(3)) u_dut3 (
        .clk  (clk),
        .rst  (rst),
        .ce   (ce),
        .din  (din3),
        .dout (dout3)
    );
`else
    assign dout3 = 8'h00;
`endif

    // Advance to 1 time unit after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reset held across exactly one rising edge; returns just after that
    // edge with rst released, so the next edge is the first one after reset.
    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        // Power-up state: rst has been high since time 0, no edge yet needed.
        checks++;
        if (dout4 !== 10'h000) begin
            failures++;
            $display("FAIL reset_state_d4 dout=%h expected=%h", dout4, 10'h000);
        end
        checks++;
        if (dout1 !== 8'h00) begin
            failures++;
            $display("FAIL reset_state_d1 dout=%h expected=%h", dout1, 8'h00);
        end
        tick();
        rst = 1'b0;

        // Fill the whole chain with all-ones.
        din4 = 10'h3FF;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (dout4 !== 10'h3FF) begin
            failures++;
            $display("FAIL reset_prefill dout=%h expected=%h", dout4, 10'h3FF);
        end

        // Asynchronous assertion in the middle of a cycle.
        #3 rst = 1'b1;
        #1;
        checks++;
        if (dout4 !== 10'h000) begin
            failures++;
            $display("FAIL reset_async dout=%h expected=%h", dout4, 10'h000);
        end
        tick();
        checks++;
        if (dout4 !== 10'h000) begin
            failures++;
            $display("FAIL reset_hold dout=%h expected=%h", dout4, 10'h000);
        end
        #4 rst = 1'b0;

        // With din=3FF held, edges 1..3 after release leave dout at 0 and the
        // 4th edge delivers the word captured at edge 1.
        for (int e = 1; e <= 4; e++) begin
            logic [9:0] exp;
            tick();
            exp = (e < 4) ? 10'h000 : 10'h3FF;
            checks++;
            if (dout4 !== exp) begin
                failures++;
                $display("FAIL reset_refill edge=%0d dout=%h expected=%h", e, dout4, exp);
            end
        end
    endtask

    task automatic test_ramp;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            logic [9:0] exp;
            din4 = 10'(k);
            tick();
            exp = (k >= 3) ? 10'(k - 3) : 10'h000;
            checks++;
            if (dout4 !== exp) begin
                failures++;
                $display("FAIL ramp k=%0d dout=%h expected=%h", k, dout4, exp);
            end
        end
    endtask

    task automatic test_bit_independence;
        logic [9:0] pat [0:13];
        logic [9:0] one;
        one = 10'h200;
        for (int k = 0; k < 14; k++) pat[k] = (k < 10) ? (one >> k) : 10'h000;
        do_reset();
        for (int k = 0; k < 14; k++) begin
            logic [9:0] exp;
            din4 = pat[k];
            tick();
            exp = (k >= 3) ? pat[k-3] : 10'h000;
            checks++;
            if (dout4 !== exp) begin
                failures++;
                $display("FAIL walking_one k=%0d dout=%h expected=%h", k, dout4, exp);
            end
        end
    endtask

    task automatic test_mid_reset;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            logic [9:0] exp;
            din4 = 10'(k);
            tick();
            exp = (k >= 3) ? 10'(k - 3) : 10'h000;
            checks++;
            if (dout4 !== exp) begin
                failures++;
                $display("FAIL midrst_ramp k=%0d dout=%h expected=%h", k, dout4, exp);
            end
        end
        // dout shows 16 here; 17..19 are in flight and 20 is on din.
        din4 = 10'd20;
        #3 rst = 1'b1;
        #1;
        checks++;
        if (dout4 !== 10'h000) begin
            failures++;
            $display("FAIL midrst_async dout=%h expected=%h", dout4, 10'h000);
        end
        tick();
        checks++;
        if (dout4 !== 10'h000) begin
            failures++;
            $display("FAIL midrst_hold dout=%h expected=%h", dout4, 10'h000);
        end
        rst = 1'b0;
        for (int j = 0; j < 8; j++) begin
            logic [9:0] exp;
            din4 = 10'(21 + j);
            tick();
            exp = (j >= 3) ? 10'(21 + j - 3) : 10'h000;
            checks++;
            if (dout4 !== exp) begin
                failures++;
                $display("FAIL midrst_refill j=%0d dout=%h expected=%h", j, dout4, exp);
            end
        end
    endtask

    task automatic test_delay0;
        din0 = 8'hA5;
        #1;
        checks++;
        if (dout0 !== 8'hA5) begin
            failures++;
            $display("FAIL delay0_a5 dout=%h expected=%h", dout0, 8'hA5);
        end
        din0 = 8'h5A;
        #1;
        checks++;
        if (dout0 !== 8'h5A) begin
            failures++;
            $display("FAIL delay0_5a dout=%h expected=%h", dout0, 8'h5A);
        end
        // Reset has no effect on the pass-through.
        rst  = 1'b1;
        din0 = 8'hC3;
        #1;
        checks++;
        if (dout0 !== 8'hC3) begin
            failures++;
            $display("FAIL delay0_rst dout=%h expected=%h", dout0, 8'hC3);
        end
        rst = 1'b0;
    endtask

    task automatic test_delay1;
        do_reset();
        din1 = 8'hA5;
        #1;
        checks++;
        if (dout1 !== 8'h00) begin
            failures++;
            $display("FAIL delay1_no_comb dout=%h expected=%h", dout1, 8'h00);
        end
        tick();
        checks++;
        if (dout1 !== 8'hA5) begin
            failures++;
            $display("FAIL delay1_a5 dout=%h expected=%h", dout1, 8'hA5);
        end
        din1 = 8'h3C;
        #1;
        checks++;
        if (dout1 !== 8'hA5) begin
            failures++;
            $display("FAIL delay1_hold dout=%h expected=%h", dout1, 8'hA5);
        end
        tick();
        checks++;
        if (dout1 !== 8'h3C) begin
            failures++;
            $display("FAIL delay1_3c dout=%h expected=%h", dout1, 8'h3C);
        end
    endtask

`ifdef DELAY_LINE_CE_EN
    task automatic test_ce;
        ce = 1'b1;
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            logic [7:0] exp;
            din3 = 8'(k);
            tick();
            exp = (k == 3) ? 8'd1 : 8'd0;
            checks++;
            if (dout3 !== exp) begin
                failures++;
                $display("FAIL ce_fill k=%0d dout=%h expected=%h", k, dout3, exp);
            end
        end
        ce = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din3 = 8'hEE;
            tick();
            checks++;
            if (dout3 !== 8'd1) begin
                failures++;
                $display("FAIL ce_hold i=%0d dout=%h expected=%h", i, dout3, 8'd1);
            end
        end
        ce = 1'b1;
        for (int k = 4; k <= 7; k++) begin
            logic [7:0] exp;
            din3 = 8'(k);
            tick();
            exp = 8'(k - 2);
            checks++;
            if (dout3 !== exp) begin
                failures++;
                $display("FAIL ce_resume k=%0d dout=%h expected=%h", k, dout3, exp);
            end
        end
        // Reset overrides a deasserted enable.
        ce  = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (dout3 !== 8'd0) begin
            failures++;
            $display("FAIL ce_rst_override dout=%h expected=%h", dout3, 8'd0);
        end
        tick();
        rst = 1'b0;
        ce  = 1'b1;
    endtask
`endif

    initial begin
        rst  = 1'b1;
        ce   = 1'b1;
        din4 = '0;
        din0 = '0;
        din1 = '0;
        din3 = '0;
        #1;
        test_reset();
        test_ramp();
        test_bit_independence();
        test_mid_reset();
        test_delay0();
        test_delay1();
`ifdef DELAY_LINE_CE_EN
        test_ce();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
